// File: rtl/sparse_rotate_accumulator_pkg.sv
// Shared definitions for the sparse rotate accumulator.
// Holds the sequencer state encoding, the sparse-entry field layout and
// the closed-form run length so that every user derives them identically.
// No ports (package).
package sparse_acc_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_POS_ADDR  = 3'd1;
  localparam state_t ST_POS_CAP   = 3'd2;
  localparam state_t ST_PREV_ADDR = 3'd3;
  localparam state_t ST_PREV_CAP  = 3'd4;
  localparam state_t ST_WORD_ADDR = 3'd5;
  localparam state_t ST_WORD_CAP  = 3'd6;
  localparam state_t ST_DONE      = 3'd7;

  // Sparse entry layout: position in bits [pos_w-1:0], valid flag just above it.
  localparam int POS_LSB = 0;

  function automatic int valid_bit(input int pos_w);
    return pos_w;
  endfunction

  // Cycles from start capture to the done pulse: 4-cycle prologue plus two
  // cycles per ring word for every entry, plus the DONE cycle.
  function automatic int run_cycles(input int num_pos, input int mem_size);
    return num_pos * (4 + 2 * mem_size) + 1;
  endfunction

endpackage

// File: rtl/sparse_rotate_accumulator_word_rotator.sv
// word_rotator: combinational slice of a cyclic left rotation.
// Produces one output word of the rotated ring from the current normal
// word and the word below it (prev), shifted by the sub-word amount b.
// A dummy entry (valid=0) yields zero so the accumulator word is unchanged.
// Ports:
//   n     in  WORD_WIDTH  current normal word
//   prev  in  WORD_WIDTH  preceding normal word (cyclic)
//   b     in  BIT_W       bit shift within a word
//   valid in  1           entry contributes
//   rot   out WORD_WIDTH  rotated word
module word_rotator
  import sparse_acc_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int BIT_W      = 5
) (
  input  logic [WORD_WIDTH-1:0] n,
  input  logic [WORD_WIDTH-1:0] prev,
  input  logic [BIT_W-1:0]      b,
  input  logic                  valid,
  output logic [WORD_WIDTH-1:0] rot
);

  // Select zero, plain word, or the two-word funnel shift.
  always_comb begin
    rot = {WORD_WIDTH{1'b0}};
    if (!valid) begin
      rot = {WORD_WIDTH{1'b0}};
    end else if (b == {BIT_W{1'b0}}) begin
      // A shift of WORD_WIDTH on prev would be out of range, so b=0 is special.
      rot = n;
    end else begin
      rot = (n << b) | (prev >> (WORD_WIDTH - int'(b)));
    end
  end

endmodule

// File: rtl/sparse_rotate_accumulator.sv
// sparse_rotate_accumulator: for each sparse entry p, XORs the normal
// polynomial rotated left by p bits (cyclic over MEM_SIZE*WORD_WIDTH bits)
// into an external accumulator memory. Timing is data independent: dummy
// and out-of-range entries run the same address/write sequence with a zero
// contribution.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start_i                   run request (ignored while busy)
//   busy_o, done_o, err_o     run active, completion pulse, sticky range error
//   sp_addr_o / sp_data_i     sparse entry memory (registered read)
//   nm_addr_o / nm_data_i     normal polynomial memory (registered read)
//   acc_rd_addr_o / acc_rd_data_i  accumulator read port (registered read)
//   acc_wr_en_o / acc_wr_addr_o / acc_wr_data_o  accumulator write port
module sparse_rotate_accumulator
  import sparse_acc_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int MEM_SIZE   = 553,
  parameter int NUM_POS    = 66,
  parameter int POS_W      = $clog2(MEM_SIZE * WORD_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [((NUM_POS > 1) ? $clog2(NUM_POS) : 1)-1:0] sp_addr_o,
  input  logic [POS_W:0]       sp_data_i,
  output logic [$clog2(MEM_SIZE)-1:0] nm_addr_o,
  input  logic [WORD_WIDTH-1:0] nm_data_i,
  output logic [$clog2(MEM_SIZE)-1:0] acc_rd_addr_o,
  input  logic [WORD_WIDTH-1:0] acc_rd_data_i,
  output logic                 acc_wr_en_o,
  output logic [$clog2(MEM_SIZE)-1:0] acc_wr_addr_o,
  output logic [WORD_WIDTH-1:0] acc_wr_data_o
);

  localparam int ADDR_W    = $clog2(MEM_SIZE);
  localparam int SP_ADDR_W = (NUM_POS > 1) ? $clog2(NUM_POS) : 1;
  localparam int BIT_W     = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int VALID_BIT = valid_bit(POS_W);

  localparam logic [POS_W:0]       RING_BITS = (POS_W+1)'(MEM_SIZE * WORD_WIDTH);
  localparam logic [POS_W-1:0]     POS_DIV   = POS_W'(WORD_WIDTH);
  localparam logic [ADDR_W:0]      MEM_WIDE  = (ADDR_W+1)'(MEM_SIZE);
  localparam logic [ADDR_W-1:0]    LAST_WORD = ADDR_W'(MEM_SIZE - 1);
  localparam logic [ADDR_W-1:0]    ADDR_ONE  = ADDR_W'(1);
  localparam logic [SP_ADDR_W-1:0] LAST_POS  = SP_ADDR_W'(NUM_POS - 1);
  localparam logic [SP_ADDR_W-1:0] SP_ONE    = SP_ADDR_W'(1);

  state_t                 state_r;
  logic [ADDR_W-1:0]      i_r;
  logic [ADDR_W-1:0]      off_r;
  logic [BIT_W-1:0]       b_r;
  logic                   valid_r;
  logic [WORD_WIDTH-1:0]  prev_r;

  logic [POS_W-1:0]       pos_s;
  logic                   entry_valid_s;
  logic                   in_range_s;
  logic [ADDR_W-1:0]      off_s;
  logic [BIT_W-1:0]       b_s;
  logic [ADDR_W:0]        acc_sum_s;
  logic [ADDR_W-1:0]      acc_next_s;
  logic [WORD_WIDTH-1:0]  rot_s;

  // Decode the sparse entry into word offset and in-word shift.
  always_comb begin
    pos_s         = sp_data_i[POS_W-1:POS_LSB];
    entry_valid_s = sp_data_i[VALID_BIT];
    in_range_s    = ({1'b0, pos_s} < RING_BITS);
    if (in_range_s) begin
      off_s = ADDR_W'(pos_s / POS_DIV);
      b_s   = BIT_W'(pos_s % POS_DIV);
    end else begin
      // Out-of-range positions would address outside the ring; pin them to 0.
      off_s = {ADDR_W{1'b0}};
      b_s   = {BIT_W{1'b0}};
    end
  end

  // Next accumulator address, wrapped by compare-subtract (sum never exceeds 2*MEM_SIZE-2).
  always_comb begin
    acc_sum_s = {1'b0, acc_rd_addr_o} + {{ADDR_W{1'b0}}, 1'b1};
    if (acc_sum_s >= MEM_WIDE) begin
      acc_next_s = ADDR_W'(acc_sum_s - MEM_WIDE);
    end else begin
      acc_next_s = acc_sum_s[ADDR_W-1:0];
    end
  end

  word_rotator #(
    .WORD_WIDTH (WORD_WIDTH),
    .BIT_W      (BIT_W)
  ) u_word_rotator (
    .n     (nm_data_i),
    .prev  (prev_r),
    .b     (b_r),
    .valid (valid_r),
    .rot   (rot_s)
  );

  // Sequencer: one state per cycle, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      i_r           <= {ADDR_W{1'b0}};
      off_r         <= {ADDR_W{1'b0}};
      b_r           <= {BIT_W{1'b0}};
      valid_r       <= 1'b0;
      prev_r        <= {WORD_WIDTH{1'b0}};
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      sp_addr_o     <= {SP_ADDR_W{1'b0}};
      nm_addr_o     <= {ADDR_W{1'b0}};
      acc_rd_addr_o <= {ADDR_W{1'b0}};
      acc_wr_en_o   <= 1'b0;
      acc_wr_addr_o <= {ADDR_W{1'b0}};
      acc_wr_data_o <= {WORD_WIDTH{1'b0}};
    end else begin
      done_o      <= 1'b0;
      acc_wr_en_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            sp_addr_o <= {SP_ADDR_W{1'b0}};
            err_o     <= 1'b0;
            busy_o    <= 1'b1;
            state_r   <= ST_POS_ADDR;
          end
        end
        ST_POS_ADDR: begin
          state_r <= ST_POS_CAP;
        end
        ST_POS_CAP: begin
          // Out-of-range valid entries behave as dummies but raise the sticky flag.
          valid_r   <= entry_valid_s & in_range_s;
          if (entry_valid_s && !in_range_s) begin
            err_o <= 1'b1;
          end
          off_r     <= off_s;
          b_r       <= b_s;
          nm_addr_o <= LAST_WORD;
          state_r   <= ST_PREV_ADDR;
        end
        ST_PREV_ADDR: begin
          state_r <= ST_PREV_CAP;
        end
        ST_PREV_CAP: begin
          // The top normal word feeds the low bits of rotated word 0.
          prev_r        <= nm_data_i;
          i_r           <= {ADDR_W{1'b0}};
          nm_addr_o     <= {ADDR_W{1'b0}};
          acc_rd_addr_o <= off_r;
          state_r       <= ST_WORD_ADDR;
        end
        ST_WORD_ADDR: begin
          state_r <= ST_WORD_CAP;
        end
        ST_WORD_CAP: begin
          acc_wr_en_o   <= 1'b1;
          acc_wr_addr_o <= acc_rd_addr_o;
          acc_wr_data_o <= acc_rd_data_i ^ rot_s;
          prev_r        <= nm_data_i;
          if (i_r == LAST_WORD) begin
            if (sp_addr_o == LAST_POS) begin
              done_o  <= 1'b1;
              busy_o  <= 1'b0;
              state_r <= ST_DONE;
            end else begin
              sp_addr_o <= sp_addr_o + SP_ONE;
              state_r   <= ST_POS_ADDR;
            end
          end else begin
            i_r           <= i_r + ADDR_ONE;
            nm_addr_o     <= i_r + ADDR_ONE;
            acc_rd_addr_o <= acc_next_s;
            state_r       <= ST_WORD_ADDR;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_rotate_accumulator.sv
// Self-checking bench for sparse_rotate_accumulator.
// Two instances share clk/rst: index 0 has one entry per run, index 1 has two.
// Both use WORD_WIDTH=32, MEM_SIZE=4 and a widened POS_W=8 so out-of-range
// positions (>=128) can be expressed. Expected accumulator contents come from
// a whole-ring 128-bit rotate model.
module tb_sparse_rotate_accumulator;

  logic clk;
  logic rst;

  logic        start  [2];
  logic        busy   [2];
  logic        done   [2];
  logic        err    [2];
  logic        we     [2];
  logic [0:0]  sp_a   [2];
  logic [8:0]  sp_d   [2];
  logic [1:0]  nm_a   [2];
  logic [1:0]  acc_ra [2];
  logic [1:0]  wa     [2];
  logic [31:0] nm_d   [2];
  logic [31:0] acc_rd [2];
  logic [31:0] wd     [2];

  logic [31:0] nm  [2][4];
  logic [31:0] acc [2][4];
  logic [31:0] pre [2][4];
  logic [8:0]  sp  [2][2];
  logic        load [2];
  int          wcnt [2];

  int errors = 0;
  int checks = 0;

  sparse_rotate_accumulator #(
    .WORD_WIDTH (32), .MEM_SIZE (4), .NUM_POS (1), .POS_W (8)
  ) u_dut0 (
    .clk (clk), .rst (rst), .start_i (start[0]),
    .busy_o (busy[0]), .done_o (done[0]), .err_o (err[0]),
    .sp_addr_o (sp_a[0]), .sp_data_i (sp_d[0]),
    .nm_addr_o (nm_a[0]), .nm_data_i (nm_d[0]),
    .acc_rd_addr_o (acc_ra[0]), .acc_rd_data_i (acc_rd[0]),
    .acc_wr_en_o (we[0]), .acc_wr_addr_o (wa[0]), .acc_wr_data_o (wd[0])
  );

  sparse_rotate_accumulator #(
    .WORD_WIDTH (32), .MEM_SIZE (4), .NUM_POS (2), .POS_W (8)
  ) u_dut1 (
    .clk (clk), .rst (rst), .start_i (start[1]),
    .busy_o (busy[1]), .done_o (done[1]), .err_o (err[1]),
    .sp_addr_o (sp_a[1]), .sp_data_i (sp_d[1]),
    .nm_addr_o (nm_a[1]), .nm_data_i (nm_d[1]),
    .acc_rd_addr_o (acc_ra[1]), .acc_rd_data_i (acc_rd[1]),
    .acc_wr_en_o (we[1]), .acc_wr_addr_o (wa[1]), .acc_wr_data_o (wd[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memories plus accumulator write port and write counter.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      sp_d[d]   <= sp[d][sp_a[d]];
      nm_d[d]   <= nm[d][nm_a[d]];
      acc_rd[d] <= acc[d][acc_ra[d]];
      if (load[d]) begin
        for (int k = 0; k < 4; k++) acc[d][k] <= pre[d][k];
        wcnt[d] <= 0;
      end else if (we[d]) begin
        acc[d][wa[d]] <= wd[d];
        wcnt[d] <= wcnt[d] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: whole-ring rotate-left by p, XORed in; dummies/out-of-range contribute nothing.
  function automatic logic [127:0] apply(input logic [127:0] a, input logic [127:0] n,
                                         input logic [8:0] e);
    int p;
    p = int'(e[7:0]);
    if (e[8] && p < 128) begin
      if (p == 0) return a ^ n;
      return a ^ ((n << p) | (n >> (128 - p)));
    end
    return a;
  endfunction

  function automatic logic oor(input logic [8:0] e);
    return e[8] && (e[7:0] >= 8'd128);
  endfunction

  function automatic logic [127:0] pack(input int d);
    logic [127:0] v;
    for (int k = 0; k < 4; k++) v[32*k +: 32] = acc[d][k];
    return v;
  endfunction

  function automatic logic [127:0] outs(input int d);
    return 128'({busy[d], done[d], err[d], we[d], sp_a[d], nm_a[d], acc_ra[d], wa[d], wd[d]});
  endfunction

  task automatic load_mem(input int d, input logic [127:0] nmv, input logic [127:0] accv);
    for (int k = 0; k < 4; k++) begin
      nm[d][k]  = nmv[32*k +: 32];
      pre[d][k] = accv[32*k +: 32];
    end
    load[d] = 1'b1;
    @(posedge clk); #1;
    load[d] = 1'b0;
  endtask

  // Pulse start, then step until done is seen or 200 cycles pass.
  task automatic run(input int d, input int extra_at, output int cyc,
                     output logic err_at_start, output logic busy_at_start);
    start[d] = 1'b1;
    @(posedge clk); #1;
    start[d] = 1'b0;
    cyc = 1;
    busy_at_start = busy[d];
    err_at_start  = err[d];
    while (cyc < 200 && !done[d]) begin
      if (cyc == extra_at) start[d] = 1'b1;
      @(posedge clk); #1;
      start[d] = 1'b0;
      cyc++;
    end
  endtask

  task automatic do_case(input string tag, input int d, input logic [127:0] nmv,
                         input logic [127:0] accv, input logic [8:0] e0, input logic [8:0] e1,
                         input int extra_at, output logic [127:0] got);
    int cyc, exp_cyc, exp_wr;
    logic eas, bas, exp_err;
    logic [127:0] exp_acc;
    sp[d][0] = e0;
    sp[d][1] = e1;
    load_mem(d, nmv, accv);
    exp_acc = apply(accv, nmv, e0);
    exp_err = oor(e0);
    exp_cyc = 13;
    exp_wr  = 4;
    if (d == 1) begin
      exp_acc = apply(exp_acc, nmv, e1);
      exp_err = exp_err | oor(e1);
      exp_cyc = 25;
      exp_wr  = 8;
    end
    run(d, extra_at, cyc, eas, bas);
    chk({tag, "/cycles"}, 128'(cyc), 128'(exp_cyc));
    chk({tag, "/busy_start"}, 128'(bas), 128'(1));
    chk({tag, "/err_start"}, 128'(eas), 128'(0));
    chk({tag, "/done"}, 128'(done[d]), 128'(1));
    chk({tag, "/busy_done"}, 128'(busy[d]), 128'(0));
    @(posedge clk); #1;
    chk({tag, "/done_pulse"}, 128'(done[d]), 128'(0));
    chk({tag, "/writes"}, 128'(wcnt[d]), 128'(exp_wr));
    chk({tag, "/acc"}, pack(d), exp_acc);
    chk({tag, "/err"}, 128'(err[d]), 128'(exp_err));
    got = pack(d);
  endtask

  initial begin
    logic [127:0] got, nmv, accv;
    logic [8:0]   e0, e1;
    int           snap;
    logic         seen_done;

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0;
      load[d]  = 1'b0;
      sp[d][0] = 9'd0;
      sp[d][1] = 9'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset0", outs(0), 128'd0);
    chk("reset1", outs(1), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Identity rotation.
    do_case("p0", 0, {32'd4, 32'd3, 32'd2, 32'd1}, 128'd0, {1'b1, 8'd0}, 9'd0, 0, got);
    chk("p0/const", got, {32'd4, 32'd3, 32'd2, 32'd1});

    // Carry across the word boundary and a whole-word offset.
    do_case("p1", 0, {32'h8000_0000, 96'd0}, 128'd0, {1'b1, 8'd1}, 9'd0, 0, got);
    chk("p1/const", got, {96'd0, 32'h0000_0001});
    do_case("p33", 0, {32'h8000_0000, 96'd0}, 128'd0, {1'b1, 8'd33}, 9'd0, 0, got);
    chk("p33/const", got, {64'd0, 32'h0000_0001, 32'd0});

    // Full-ring wrap.
    do_case("p127", 0, 128'd1, 128'd0, {1'b1, 8'd127}, 9'd0, 0, got);
    chk("p127/const", got, {32'h8000_0000, 96'd0});

    // Out-of-range position sets err and leaves acc untouched; next run clears err.
    accv = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h5555_AAAA};
    do_case("p128", 0, {32'd9, 32'd8, 32'd7, 32'd6}, accv, {1'b1, 8'd128}, 9'd0, 0, got);
    chk("p128/const", got, accv);
    chk("p128/err_held", 128'(err[0]), 128'(1));
    do_case("after_err", 0, {32'd9, 32'd8, 32'd7, 32'd6}, accv, {1'b1, 8'd64}, 9'd0, 0, got);

    // Dummy then valid entry on the two-entry instance.
    do_case("two", 1, {32'd4, 32'd3, 32'd2, 32'd1},
            {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
            {1'b0, 8'd5}, {1'b1, 8'd0}, 0, got);
    chk("two/const", got, {32'h4444_4440, 32'h3333_3330, 32'h2222_2220, 32'h1111_1110});

    // Randomized runs on both instances.
    for (int k = 0; k < 8; k++) begin
      nmv  = {$urandom, $urandom, $urandom, $urandom};
      accv = {$urandom, $urandom, $urandom, $urandom};
      e0   = {($urandom_range(0, 3) != 0), 8'($urandom_range(0, 160))};
      e1   = {($urandom_range(0, 3) != 0), 8'($urandom_range(0, 160))};
      do_case($sformatf("rnd%0d", k), k % 2, nmv, accv, e0, e1, 0, got);
    end

    // A second start while busy must not extend or repeat the run.
    nmv = {32'hCAFE_F00D, 32'h1234_5678, 32'h0F0F_0F0F, 32'hA5A5_5A5A};
    do_case("busy_start", 0, nmv, 128'd0, {1'b1, 8'd45}, 9'd0, 5, got);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_start/idle", 128'(busy[0]), 128'(0));

    // Reset in the middle of a run: one write already in flight, nothing after.
    sp[0][0] = {1'b1, 8'd3};
    load_mem(0, nmv, 128'd0);
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    snap = wcnt[0];
    chk("rst/writes_before", 128'(snap), 128'(1));
    chk("rst/outs", outs(0), 128'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done[0]) seen_done = 1'b1;
    end
    chk("rst/no_writes", 128'(wcnt[0]), 128'(snap));
    chk("rst/no_done", 128'(seen_done), 128'(0));
    chk("rst/outs_after", outs(0), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
